// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Handshake and status bundle of one inter-stage pipeline
//               register. master = stage-side environment (upstream stage,
//               downstream stage, hazard unit); slave = pipe_stage_reg.
// Ports       : in_valid/in_ready/in_data/in_ctrl   upstream handshake
//               out_valid/out_ready/out_data/out_ctrl downstream handshake
//               flush, bubble, bubble_ack             hazard unit controls
//               stall_cnt                             saturating stall count
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              bubble;
   logic              bubble_ack;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output in_valid, in_data, in_ctrl, flush, bubble, out_ready,
      input  in_ready, bubble_ack, out_valid, out_data, out_ctrl, stall_cnt
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, flush, bubble, out_ready,
      output in_ready, bubble_ack, out_valid, out_data, out_ctrl, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register carrying a data bundle and a
//               control bundle with valid/ready back-pressure, synchronous
//               flush, hazard-driven NOP bubble insertion and a saturating
//               stall-cycle counter.
//               Macro PIPE_SKID_EN adds a second (skid) entry so in_ready is
//               a registered signal with no combinational path from
//               out_ready. Undefined: single entry, no skid storage.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active-high
//               bus  - pipe_stage_reg_if.slave (handshakes, flush/bubble,
//                      bubble_ack, stall_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   pipe_stage_reg_if.slave   bus
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [DATA_W-1:0] r_out_data;
   logic [CTRL_W-1:0] r_out_ctrl;
   logic              r_bubble_ack;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_out_valid;
   logic              w_in_ready;
   logic              w_in_xfer;
   logic              w_out_xfer;

   assign w_in_xfer  = bus.in_valid && w_in_ready;
   assign w_out_xfer = w_out_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic              w_bubble_ok;

   assign w_out_valid = (r_state != S_EMPTY);
   // Depends only on registered occupancy (and the hazard request), never on out_ready.
   assign w_in_ready  = !bus.bubble && (r_state != S_FULL);
   // A NOP may enter the main entry only if it is free this edge and no older skid word waits.
   assign w_bubble_ok = (r_state == S_EMPTY) || ((r_state == S_ONE) && bus.out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_EMPTY;
         r_out_data   <= '0;
         r_out_ctrl   <= '0;
         r_skid_data  <= '0;
         r_skid_ctrl  <= '0;
         r_bubble_ack <= 1'b0;
      end else if (bus.flush) begin
         r_state      <= S_EMPTY;
         r_out_ctrl   <= '0;
         r_skid_ctrl  <= '0;
         r_bubble_ack <= 1'b0;
      end else if (bus.bubble) begin
         if (w_bubble_ok) begin
            r_state      <= S_ONE;
            r_out_data   <= '0;
            r_out_ctrl   <= '0;
            r_bubble_ack <= 1'b1;
         end else begin
            r_bubble_ack <= 1'b0;
         end
      end else begin
         r_bubble_ack <= 1'b0;
         case (r_state)
            S_EMPTY: begin
               if (w_in_xfer) begin
                  r_out_data <= bus.in_data;
                  r_out_ctrl <= bus.in_ctrl;
                  r_state    <= S_ONE;
               end
            end
            S_ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  r_out_data <= bus.in_data;
                  r_out_ctrl <= bus.in_ctrl;
               end else if (w_in_xfer) begin
                  // Main entry is stalled: park the newer word behind it.
                  r_skid_data <= bus.in_data;
                  r_skid_ctrl <= bus.in_ctrl;
                  r_state     <= S_FULL;
               end else if (w_out_xfer) begin
                  r_state <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (w_out_xfer) begin
                  r_out_data  <= r_skid_data;
                  r_out_ctrl  <= r_skid_ctrl;
                  r_skid_ctrl <= '0;
                  r_state     <= S_ONE;
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end
`else
   logic r_out_valid;
   logic w_load;

   assign w_out_valid = r_out_valid;
   assign w_load      = !r_out_valid || bus.out_ready;
   assign w_in_ready  = !bus.bubble && w_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_ctrl   <= '0;
         r_bubble_ack <= 1'b0;
      end else if (bus.flush) begin
         r_out_valid  <= 1'b0;
         r_out_ctrl   <= '0;
         r_bubble_ack <= 1'b0;
      end else if (bus.bubble) begin
         if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= '0;
            r_out_ctrl   <= '0;
            r_bubble_ack <= 1'b1;
         end else begin
            r_bubble_ack <= 1'b0;
         end
      end else begin
         r_bubble_ack <= 1'b0;
         if (w_load) begin
            r_out_valid <= w_in_xfer;
            if (w_in_xfer) begin
               r_out_data <= bus.in_data;
               r_out_ctrl <= bus.in_ctrl;
            end
         end
      end
   end
`endif

   // Counts edges where downstream back-pressure holds a valid word; a flush edge is not a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (!bus.flush && w_out_valid && !bus.out_ready && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_ctrl   = r_out_ctrl;
   assign bus.bubble_ack = r_bubble_ack;
   assign bus.stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A scoreboard queue
//               holds the words the stage should present, in order; the
//               monitor predicts in_ready, out_valid, bubble_ack and
//               stall_cnt from the queue occupancy and compares every cycle.
//               Builds with or without PIPE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 16;
   localparam int SAT_W  = 4;
`ifdef PIPE_SKID_EN
   localparam bit c_skid = 1'b1;
`else
   localparam bit c_skid = 1'b0;
`endif

   logic clk;
   logic rst;

   pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bif ();
   pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) sif ();

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: {data, ctrl} of every word the stage holds, oldest first.
   logic [DATA_W+CTRL_W-1:0] sb_q[$];
   logic                     exp_ack;
   logic [CNT_W-1:0]         exp_cnt;

   logic [DATA_W+CTRL_W-1:0] m_head;
   int                       m_sz;
   logic                     m_rdy;
   logic                     m_ins;
   logic                     m_in_x;
   logic                     m_out_x;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         m_sz  = sb_q.size();
         m_rdy = !bif.bubble && (c_skid ? (m_sz < 2) : ((m_sz == 0) || bif.out_ready));
         n_checks++;
         if (bif.in_ready !== m_rdy) begin
            n_fail++;
            $display("FAIL mon_in_ready t=%0t got %b expected %b", $time, bif.in_ready, m_rdy);
         end
         n_checks++;
         if (bif.out_valid !== (m_sz > 0)) begin
            n_fail++;
            $display("FAIL mon_out_valid t=%0t got %b expected %b", $time, bif.out_valid, (m_sz > 0));
         end
         if (m_sz > 0) begin
            m_head = sb_q[0];
            n_checks++;
            if ({bif.out_data, bif.out_ctrl} !== m_head) begin
               n_fail++;
               $display("FAIL mon_out_word t=%0t got %h_%h expected %h_%h", $time,
                        bif.out_data, bif.out_ctrl, m_head[DATA_W+CTRL_W-1:CTRL_W], m_head[CTRL_W-1:0]);
            end
         end
         n_checks++;
         if (bif.bubble_ack !== exp_ack) begin
            n_fail++;
            $display("FAIL mon_bubble_ack t=%0t got %b expected %b", $time, bif.bubble_ack, exp_ack);
         end
         n_checks++;
         if (bif.stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL mon_stall_cnt t=%0t got %0d expected %0d", $time, bif.stall_cnt, exp_cnt);
         end

         // Predict the effect of the coming edge.
         if (bif.flush) begin
            sb_q.delete();
            exp_ack = 1'b0;
         end else begin
            m_ins   = bif.bubble && ((m_sz == 0) || ((m_sz == 1) && bif.out_ready));
            m_out_x = (m_sz > 0) && bif.out_ready;
            m_in_x  = bif.in_valid && m_rdy;
            if ((m_sz > 0) && !bif.out_ready && (exp_cnt != {CNT_W{1'b1}}))
               exp_cnt = exp_cnt + 1'b1;
            if (m_out_x)
               void'(sb_q.pop_front());
            if (m_ins)
               sb_q.push_back('0);
            else if (m_in_x)
               sb_q.push_back({bif.in_data, bif.in_ctrl});
            exp_ack = m_ins;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle;
      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.in_ctrl   = '0;
      bif.flush     = 1'b0;
      bif.bubble    = 1'b0;
      bif.out_ready = 1'b1;
   endtask

   task automatic clear_model;
      sb_q.delete();
      exp_ack = 1'b0;
      exp_cnt = '0;
   endtask

   task automatic do_reset;
      @(posedge clk);
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      clear_model();
   endtask

   task automatic test_reset;
      drive_idle();
      tick();
      tick();
      rst = 1'b0;
      clear_model();
      #1;
      n_checks++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL por_out_valid got %b expected 0", bif.out_valid); end
      n_checks++; if (bif.out_data !== '0) begin n_fail++; $display("FAIL por_out_data got %h expected 0", bif.out_data); end
      n_checks++; if (bif.out_ctrl !== '0) begin n_fail++; $display("FAIL por_out_ctrl got %h expected 0", bif.out_ctrl); end
      n_checks++; if (bif.bubble_ack !== 1'b0) begin n_fail++; $display("FAIL por_bubble_ack got %b expected 0", bif.bubble_ack); end
      n_checks++; if (bif.stall_cnt !== '0) begin n_fail++; $display("FAIL por_stall_cnt got %0d expected 0", bif.stall_cnt); end
      n_checks++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL por_in_ready got %b expected 1", bif.in_ready); end
      // Mid-stream asynchronous reset with a word held under back-pressure.
      tick();
      bif.in_valid  = 1'b1;
      bif.in_data   = 32'h0000_1234;
      bif.in_ctrl   = 16'h0055;
      bif.out_ready = 1'b0;
      tick();
      bif.in_valid = 1'b0;
      n_checks++; if (bif.out_data !== 32'h0000_1234) begin n_fail++; $display("FAIL mid_held_data got %h expected 00001234", bif.out_data); end
      #1 rst = 1'b1;
      #1;
      n_checks++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_out_valid got %b expected 0", bif.out_valid); end
      n_checks++; if (bif.out_data !== '0) begin n_fail++; $display("FAIL async_out_data got %h expected 0", bif.out_data); end
      n_checks++; if (bif.stall_cnt !== '0) begin n_fail++; $display("FAIL async_stall_cnt got %0d expected 0", bif.stall_cnt); end
      n_checks++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready got %b expected 1", bif.in_ready); end
      #1 rst = 1'b0;
      clear_model();
      bif.out_ready = 1'b1;
   endtask

   task automatic test_pass_through;
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] c;
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d = (i == 0) ? 32'hA5A5_0001 : DATA_W'($urandom);
         c = (i == 0) ? 16'h00F3 : CTRL_W'($urandom);
         bif.in_data = d;
         bif.in_ctrl = c;
         tick();
         n_checks++;
         if (bif.out_valid !== 1'b1 || bif.out_data !== d || bif.out_ctrl !== c) begin
            n_fail++;
            $display("FAIL pass_word%0d got v=%b %h_%h expected v=1 %h_%h", i, bif.out_valid, bif.out_data, bif.out_ctrl, d, c);
         end
      end
      bif.in_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_stall;
      do_reset();
      tick();
      bif.in_valid  = 1'b1;
      bif.in_data   = 32'hCAFE_0001;
      bif.in_ctrl   = 16'h0101;
      bif.out_ready = 1'b0;
      tick();
      bif.in_data = 32'hCAFE_0002;
      bif.in_ctrl = 16'h0202;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (c_skid && i == 0) bif.in_valid = 1'b0;
         n_checks++;
         if (bif.out_data !== 32'hCAFE_0001 || bif.out_ctrl !== 16'h0101) begin
            n_fail++;
            $display("FAIL stall_hold%0d got %h_%h expected cafe0001_0101", i, bif.out_data, bif.out_ctrl);
         end
      end
      n_checks++;
      if (bif.stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt5 got %0d expected 5", bif.stall_cnt); end
      bif.out_ready = 1'b1;
      tick();
      bif.in_valid = 1'b0;
      n_checks++;
      if (bif.out_valid !== 1'b1 || bif.out_data !== 32'hCAFE_0002) begin
         n_fail++;
         $display("FAIL stall_second got v=%b %h expected v=1 cafe0002", bif.out_valid, bif.out_data);
      end
      tick();
      n_checks++;
      if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained got %b expected 0", bif.out_valid); end
   endtask

   task automatic test_bubble;
      do_reset();
      tick();
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      bif.in_data   = 32'h0000_0077;
      bif.in_ctrl   = 16'h0011;
      bif.bubble    = 1'b1;
      #1;
      n_checks++; if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bubble_in_ready got %b expected 0", bif.in_ready); end
      tick();
      n_checks++;
      if (bif.out_valid !== 1'b1 || bif.out_data !== '0 || bif.out_ctrl !== '0 || bif.bubble_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL bubble_nop got v=%b %h_%h ack=%b expected v=1 0_0 ack=1", bif.out_valid, bif.out_data, bif.out_ctrl, bif.bubble_ack);
      end
      bif.bubble = 1'b0;
      tick();
      bif.in_valid = 1'b0;
      n_checks++;
      if (bif.out_data !== 32'h0000_0077 || bif.out_ctrl !== 16'h0011 || bif.bubble_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL bubble_after got %h_%h ack=%b expected 00000077_0011 ack=0", bif.out_data, bif.out_ctrl, bif.bubble_ack);
      end
      tick();
   endtask

   task automatic test_flush_bubble;
      do_reset();
      tick();
      bif.out_ready = 1'b0;
      bif.in_valid  = 1'b1;
      bif.in_data   = 32'h1111_1111;
      bif.in_ctrl   = 16'h00AA;
      tick();
      bif.in_data = 32'h2222_2222;
      bif.in_ctrl = 16'h00BB;
      tick();
      bif.in_data = 32'h3333_3333;
      bif.flush   = 1'b1;
      bif.bubble  = 1'b1;
      tick();
      bif.flush    = 1'b0;
      bif.bubble   = 1'b0;
      bif.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bif.out_valid !== 1'b0 || bif.out_ctrl !== '0 || bif.bubble_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_state got v=%b ctrl=%h ack=%b expected v=0 ctrl=0 ack=0", bif.out_valid, bif.out_ctrl, bif.bubble_ack);
      end
      n_checks++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b expected 1", bif.in_ready); end
      n_checks++; if (bif.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_stall_cnt got %0d expected 1", bif.stall_cnt); end
      n_checks++; if (bif.out_data !== 32'h1111_1111) begin n_fail++; $display("FAIL flush_data_hold got %h expected 11111111", bif.out_data); end
      bif.out_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_saturation;
      tick();
      sif.in_valid  = 1'b1;
      sif.in_data   = 32'h0000_0005;
      sif.in_ctrl   = 16'h0001;
      sif.out_ready = 1'b0;
      tick();
      sif.in_valid = 1'b0;
      repeat (20) tick();
      n_checks++; if (sif.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d expected 15", sif.stall_cnt); end
      repeat (3) tick();
      n_checks++; if (sif.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d expected 15", sif.stall_cnt); end
      n_checks++; if (sif.out_data !== 32'h0000_0005) begin n_fail++; $display("FAIL sat_data got %h expected 00000005", sif.out_data); end
      sif.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         bif.in_valid  = ($urandom_range(0, 3) != 0);
         bif.in_data   = DATA_W'($urandom);
         bif.in_ctrl   = CTRL_W'($urandom);
         bif.out_ready = ($urandom_range(0, 2) != 0);
         bif.bubble    = ($urandom_range(0, 7) == 0);
         bif.flush     = ($urandom_range(0, 15) == 0);
      end
      tick();
      drive_idle();
      repeat (4) tick();
      n_checks++;
      if (bif.out_valid !== 1'b0 || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain got v=%b pending=%0d expected v=0 pending=0", bif.out_valid, sb_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_model();
      drive_idle();
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.in_ctrl   = '0;
      sif.flush     = 1'b0;
      sif.bubble    = 1'b0;
      sif.out_ready = 1'b1;
      test_reset();
      test_pass_through();
      test_stall();
      test_bubble();
      test_flush_bubble();
      test_saturation();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
